// File: rtl/word_deser_8x32.sv
`default_nettype none
// ============================================================================
// Module   : word_deser_8x32
// Purpose  : Serial-to-parallel word loader for the SHA-256 datapath. Words
//            arrive one per valid/ready handshake, each is written into its
//            own slot of a register bank, and the complete bank is presented
//            as one wide block (e.g. H0..H7 or half a message block).
//
// Ports    : clk_i         rising-edge clock
//            rst_i         asynchronous active-high reset
//            clear_i       synchronous abort, zeroes the bank and restarts
//            din_valid_i   input word valid
//            din_ready_o   loader accepts a word this cycle (FILL state)
//            din_i         input word, WORD_W bits
//            wr_idx_o      slot the next accepted word goes to
//            dout_valid_o  complete block available (registered)
//            dout_ready_i  consumer takes the block
//            dout_o        block, word 0 in the MSBs
//
// Options  : WORD_DESER_BYTE_SWAP_EN - when defined, each accepted word is
//            byte-reversed before storage (little-endian host to big-endian).
//
// Revision : 1.0 - initial release
// ============================================================================
module word_deser_8x32 #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8,
   parameter int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic                          din_valid_i,
   output logic                          din_ready_o,
   input  logic [WORD_W-1:0]             din_i,
   output logic [IDX_W-1:0]              wr_idx_o,
   output logic                          dout_valid_o,
   input  logic                          dout_ready_i,
   output logic [WORD_W*NUM_WORDS-1:0]   dout_o
);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
   logic                dout_valid_q, dout_valid_d;
   logic [WORD_W-1:0]   slot_q [NUM_WORDS];
   logic [WORD_W-1:0]   slot_d [NUM_WORDS];
   logic [WORD_W-1:0]   din_store;
   logic                accept;

   // --------------------------------------------------------------------
   // Optional byte reversal of the incoming word
   // --------------------------------------------------------------------
`ifdef WORD_DESER_BYTE_SWAP_EN
   // Byte b of the input lands in byte (NBYTES-1-b), so din_i[7:0]
   // becomes the most significant byte of the stored word.
   localparam int NBYTES = WORD_W / 8;
   for (genvar b = 0; b < NBYTES; b++) begin : g_swap
      assign din_store[8*(NBYTES-b)-1 -: 8] = din_i[8*b +: 8];
   end
`else
   assign din_store = din_i;
`endif

   // Ready is purely a function of state; holding it low during reset keeps
   // an upstream producer from believing a word was taken while rst_i is high.
   assign din_ready_o = (state_q == ST_FILL) & ~rst_i;
   assign accept      = din_valid_i & din_ready_o;

   // --------------------------------------------------------------------
   // Next-state / datapath logic
   // --------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      wr_idx_d     = wr_idx_q;
      dout_valid_d = dout_valid_q;
      slot_d       = slot_q;

      if (clear_i) begin
         // Abort wins over any handshake in the same cycle.
         state_d      = ST_FILL;
         wr_idx_d     = '0;
         dout_valid_d = 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            slot_d[k] = '0;
         end
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  slot_d[wr_idx_q] = din_store;
                  // NUM_WORDS is a power of two, so the increment wraps
                  // to zero naturally after the last slot.
                  wr_idx_d = wr_idx_q + IDX_W'(1);
                  if (wr_idx_q == LAST_IDX) begin
                     state_d      = ST_FULL;
                     dout_valid_d = 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (dout_valid_q && dout_ready_i) begin
                  state_d      = ST_FILL;
                  dout_valid_d = 1'b0;
               end
            end
            default: begin
               state_d      = ST_FILL;
               dout_valid_d = 1'b0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_FILL;
         wr_idx_q     <= '0;
         dout_valid_q <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         wr_idx_q     <= wr_idx_d;
         dout_valid_q <= dout_valid_d;
         for (int k = 0; k < NUM_WORDS; k++) begin
            slot_q[k] <= slot_d[k];
         end
      end
   end

   // --------------------------------------------------------------------
   // Output packing: word k at [WORD_W*(NUM_WORDS-k)-1 -: WORD_W]
   // --------------------------------------------------------------------
   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_pack
      assign dout_o[WORD_W*(NUM_WORDS-k)-1 -: WORD_W] = slot_q[k];
   end

   assign wr_idx_o     = wr_idx_q;
   assign dout_valid_o = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_word_deser_8x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_deser_8x32
// Purpose  : Self-checking bench for word_deser_8x32. A table of vectors
//            covers the first block, hand-written sequences cover hold,
//            release, gaps, clear and asynchronous reset, and a random phase
//            is checked against a behavioural block model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_deser_8x32;

   localparam int W = 32;
   localparam int N = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            clear;
   logic            din_valid;
   logic            din_ready;
   logic [W-1:0]    din;
   logic [2:0]      wr_idx;
   logic            dout_valid;
   logic            dout_ready;
   logic [W*N-1:0]  dout;

   int checks = 0;
   int errors = 0;

   // Behavioural model: count of words held, whether a block is pending,
   // and the slot contents.
   int              m_cnt;
   bit              m_full;
   logic [W-1:0]    m_slot [N];

   word_deser_8x32 dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .din_valid_i  (din_valid),
      .din_ready_o  (din_ready),
      .din_i        (din),
      .wr_idx_o     (wr_idx),
      .dout_valid_o (dout_valid),
      .dout_ready_i (dout_ready),
      .dout_o       (dout)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] bsw(input logic [W-1:0] w);
`ifdef WORD_DESER_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [W*N-1:0] m_block();
      logic [W*N-1:0] b = '0;
      for (int k = 0; k < N; k++) b = {b[W*(N-1)-1:0], m_slot[k]};
      return b;
   endfunction

   task automatic m_reset();
      m_cnt  = 0;
      m_full = 0;
      for (int k = 0; k < N; k++) m_slot[k] = '0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic m_step();
      if (clear) begin
         m_reset();
      end else if (m_full) begin
         if (dout_ready) m_full = 0;
      end else if (din_valid) begin
         m_slot[m_cnt] = bsw(din);
         m_cnt = (m_cnt + 1) % N;
         if (m_cnt == 0) m_full = 1;
      end
   endtask

   task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string name);
      chk({name, ".ready"}, W*N'(din_ready), W*N'(!m_full));
      chk({name, ".idx"},   W*N'(wr_idx),    W*N'(m_cnt));
      chk({name, ".valid"}, W*N'(dout_valid), W*N'(m_full));
      chk({name, ".dout"},  dout, m_block());
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      din_valid  = 0;
      dout_ready = 0;
      clear      = 0;
      din        = '0;
   endtask

   task automatic send(input logic [W-1:0] w);
      din_valid = 1;
      din       = w;
      cyc();
      din_valid = 0;
   endtask

   typedef struct {
      logic         valid;
      logic [W-1:0] din;
      logic         ready;
      logic         exp_rdy;
      logic [2:0]   exp_idx;
      logic         exp_vld;
   } vec_t;

   vec_t             vt [10];
   logic [W*N-1:0]   blk1;
   logic [W*N-1:0]   held;
   int               acc;

   initial begin
      // ---------------- reset ----------------
      idle_inputs();
      rst = 1;
      m_reset();
      #2;
      chk("rst.ready", W*N'(din_ready), '0);
      chk("rst.idx",   W*N'(wr_idx),    '0);
      chk("rst.valid", W*N'(dout_valid), '0);
      chk("rst.dout",  dout, '0);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
      chk("post_rst.ready", W*N'(din_ready), W*N'(1));

      // ---------------- table: first block ----------------
      for (int k = 0; k < 8; k++)
         vt[k] = '{1'b1, W'(k + 1), 1'b0, (k != 7), 3'((k + 1) % 8), (k == 7)};
      vt[8] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, 1'b1};  // ignored while FULL
      vt[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 3'd0, 1'b1};
      blk1 = '0;
      for (int k = 0; k < N; k++) blk1 = {blk1[W*(N-1)-1:0], bsw(W'(k + 1))};

      for (int i = 0; i < 10; i++) begin
         din_valid  = vt[i].valid;
         din        = vt[i].din;
         dout_ready = vt[i].ready;
         cyc();
         chk($sformatf("tbl%0d.ready", i), W*N'(din_ready),  W*N'(vt[i].exp_rdy));
         chk($sformatf("tbl%0d.idx", i),   W*N'(wr_idx),     W*N'(vt[i].exp_idx));
         chk($sformatf("tbl%0d.valid", i), W*N'(dout_valid), W*N'(vt[i].exp_vld));
      end
      idle_inputs();
      chk("blk1.dout", dout, blk1);

      // ---------------- hold 5 cycles then release ----------------
      held = dout;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("hold%0d.dout", i), dout, blk1);
         chk($sformatf("hold%0d.valid", i), W*N'(dout_valid), W*N'(1));
      end
      dout_ready = 1;
      cyc();
      dout_ready = 0;
      chk("release.valid", W*N'(dout_valid), '0);
      chk("release.ready", W*N'(din_ready), W*N'(1));
      chk("release.dout_kept", dout, held);

      // ---------------- second block ----------------
      for (int k = 0; k < N; k++) send(32'hA000_0000 + W'(k));
      chk_model("blk2");
      dout_ready = 1;
      cyc();
      dout_ready = 0;
      chk_model("blk2_rel");

      // ---------------- random gaps, DEADBEEF ----------------
      acc = 0;
      for (int i = 0; i < 200 && acc < N; i++) begin
         din_valid = $urandom_range(0, 2) == 0;
         din       = 32'hDEAD_BEEF;
         if (din_valid) acc++;
         cyc();
         chk_model($sformatf("gap%0d", i));
      end
      din_valid = 0;
      chk("gap.full", W*N'(dout_valid), W*N'(1));
      chk("gap.dout", dout, {N{bsw(32'hDEAD_BEEF)}});
      dout_ready = 1;
      cyc();
      dout_ready = 0;

      // ---------------- clear mid-fill ----------------
      for (int k = 0; k < 3; k++) send(32'h1111_0000 + W'(k));
      clear     = 1;
      din_valid = 1;
      din       = 32'h4444_4444;
      cyc();
      idle_inputs();
      chk("clr.idx",   W*N'(wr_idx), '0);
      chk("clr.dout",  dout, '0);
      chk("clr.valid", W*N'(dout_valid), '0);
      for (int k = 0; k < N; k++) send(32'h5555_0000 + W'(k));
      chk_model("after_clr");
      chk("after_clr.w0", W*N'(dout[W*N-1 -: W]), W*N'(bsw(32'h5555_0000)));

      // ---------------- async reset mid-FULL ----------------
      cyc();
      chk("pre_arst.valid", W*N'(dout_valid), W*N'(1));
      #2;
      rst = 1;
      m_reset();
      #1;
      chk("arst.valid", W*N'(dout_valid), '0);
      chk("arst.idx",   W*N'(wr_idx), '0);
      chk("arst.ready", W*N'(din_ready), '0);
      chk("arst.dout",  dout, '0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("arst_rel.ready", W*N'(din_ready), W*N'(1));

      // ---------------- byte order of slot 0 ----------------
      send(32'h1122_3344);
`ifdef WORD_DESER_BYTE_SWAP_EN
      chk("swap.w0", W*N'(dout[255:224]), W*N'(32'h4433_2211));
`else
      chk("noswap.w0", W*N'(dout[255:224]), W*N'(32'h1122_3344));
`endif
      clear = 1;
      cyc();
      clear = 0;

      // ---------------- random traffic vs model ----------------
      for (int i = 0; i < 400; i++) begin
         din_valid  = $urandom_range(0, 1) == 1;
         din        = $urandom;
         dout_ready = $urandom_range(0, 3) == 0;
         clear      = $urandom_range(0, 24) == 0;
         cyc();
         chk_model($sformatf("rnd%0d", i));
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
